mc_proc_controller: RTL and testbench

//  Multi-cycle successor to the single-cycle processor controller: same ISA encoding, but sequenced by an FSM.

---
 rtl/mc_proc_controller_if.sv | 33 +++
 rtl/mc_proc_controller.sv | 225 ++++++++++++++++++++++
 tb/tb_mc_proc_controller.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_proc_controller_if.sv
// Memory-side handshake bundle for the multi-cycle controller:
// instruction fetch port and data access port, each with a req/ack pair.
interface mc_proc_controller_if #(
  parameter int REG_IDX_W = 4,
  parameter int IMM_W     = 16
);
  localparam int INSTR_W = 8 + IMM_W + 2 * REG_IDX_W;

  logic               imem_req;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               dmem_req;
  logic               dmem_we;
  logic               dmem_ack;

  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_ack,
    input  imem_rdata,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_ack,
    output imem_rdata,
    output dmem_ack
  );
endinterface

// File: rtl/mc_proc_controller.sv
// Multi-cycle processor controller: sequences fetch, decode, execute, memory
// and write-back with req/ack memory handshakes, an illegal-opcode trap and a retire counter.
module mc_proc_controller #(
  parameter int REG_IDX_W = 4,
  parameter int IMM_W     = 16,
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mc_proc_controller_if.master memBus,
  input  logic                 alu_out,
  output logic                 pc_we,
  output logic [1:0]           pc_sel,
  output logic                 reg_wr_en,
  output logic [1:0]           reg_wr_sel,
  output logic [REG_IDX_W-1:0] rd0_idx,
  output logic [REG_IDX_W-1:0] rd1_idx,
  output logic [REG_IDX_W-1:0] wr_idx,
  output logic [3:0]           alu_func,
  output logic                 alu_alt_op,
  output logic                 alu_src2_sel,
  output logic [IMM_W-1:0]     imm,
  output logic                 retire,
  output logic [INSTRET_W-1:0] instret,
  output logic                 trap
);

  localparam int INSTR_W = 8 + IMM_W + 2 * REG_IDX_W;

  localparam logic [3:0] OP_ALU_R  = 4'b0000;
  localparam logic [3:0] OP_ALU_I  = 4'b1000;
  localparam logic [3:0] OP_CMP_R  = 4'b0010;
  localparam logic [3:0] OP_CMP_I  = 4'b1010;
  localparam logic [3:0] OP_STORE  = 4'b0101;
  localparam logic [3:0] OP_LOAD   = 4'b1001;
  localparam logic [3:0] OP_BRANCH = 4'b0110;
  localparam logic [3:0] OP_JAL    = 4'b1011;

  localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
  localparam logic [1:0] PC_SEL_REL  = 2'b01;
  localparam logic [1:0] PC_SEL_REG  = 2'b10;
  localparam logic [1:0] WR_SEL_ALU  = 2'b00;
  localparam logic [1:0] WR_SEL_MEM  = 2'b01;
  localparam logic [1:0] WR_SEL_LINK = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  state_t               state;
  state_t               nextState;
  logic [INSTR_W-1:0]   ir;

  logic [3:0]           opcode;
  logic [REG_IDX_W-1:0] rdField;
  logic [REG_IDX_W-1:0] rs1Field;
  logic [REG_IDX_W-1:0] rs2Field;
  logic [IMM_W-1:0]     immField;

  logic isAluR, isAluI, isCmpR, isCmpI;
  logic isStore, isLoad, isBranch, isJal;
  logic isRType, isIType, isCmp, writesReg, isLegal;
  logic fieldsValid;

  // rs2 sits directly below rs1 and shares bits with the top of the immediate.
  assign opcode   = ir[3:0];
  assign immField = ir[8 +: IMM_W];
  assign rdField  = ir[INSTR_W-1 -: REG_IDX_W];
  assign rs1Field = ir[INSTR_W-REG_IDX_W-1 -: REG_IDX_W];
  assign rs2Field = ir[INSTR_W-2*REG_IDX_W-1 -: REG_IDX_W];

  assign isAluR   = (opcode == OP_ALU_R);
  assign isAluI   = (opcode == OP_ALU_I);
  assign isCmpR   = (opcode == OP_CMP_R);
  assign isCmpI   = (opcode == OP_CMP_I);
  assign isStore  = (opcode == OP_STORE);
  assign isLoad   = (opcode == OP_LOAD);
  assign isBranch = (opcode == OP_BRANCH);
  assign isJal    = (opcode == OP_JAL);

  assign isRType   = isAluR | isCmpR;
  assign isIType   = isAluI | isCmpI | isLoad | isJal;
  assign isCmp     = isCmpR | isCmpI;
  assign writesReg = isRType | isIType;
  assign isLegal   = writesReg | isStore | isBranch;

  // Decoded fields are presented only once an instruction is in flight.
  assign fieldsValid = isLegal &&
                       ((state == S_DECODE) || (state == S_EXEC) ||
                        (state == S_MEM)    || (state == S_WB));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      // NOTE: IR is a single architectural register, not a memory array, so
      // it is reset to keep decode outputs defined straight after reset.
      ir      <= '0;
      instret <= '0;
    end else begin
      state <= nextState;
      if ((state == S_FETCH) && memBus.imem_ack) begin
        ir <= memBus.imem_rdata;
      end
      if (retire) begin
        instret <= instret + INSTRET_W'(1);
      end
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can leave a variable unassigned (latch).
  always_comb begin
    nextState       = state;
    memBus.imem_req = 1'b0;
    memBus.dmem_req = 1'b0;
    memBus.dmem_we  = 1'b0;
    pc_we           = 1'b0;
    pc_sel          = PC_SEL_SEQ;
    reg_wr_en       = 1'b0;
    reg_wr_sel      = WR_SEL_ALU;
    retire          = 1'b0;
    trap            = 1'b0;

    unique case (state)
      S_IDLE: begin
        nextState = S_FETCH;
      end

      S_FETCH: begin
        memBus.imem_req = 1'b1;
        if (memBus.imem_ack) begin
          nextState = S_DECODE;
        end
      end

      S_DECODE: begin
        nextState = isLegal ? S_EXEC : S_TRAP;
      end

      S_EXEC: begin
        if (isBranch) begin
          pc_we     = 1'b1;
          pc_sel    = alu_out ? PC_SEL_REL : PC_SEL_SEQ;
          retire    = 1'b1;
          nextState = S_FETCH;
        end else if (isLoad || isStore) begin
          nextState = S_MEM;
        end else begin
          nextState = S_WB;
        end
      end

      S_MEM: begin
        memBus.dmem_req = 1'b1;
        memBus.dmem_we  = isStore;
        if (memBus.dmem_ack) begin
          if (isStore) begin
            pc_we     = 1'b1;
            retire    = 1'b1;
            nextState = S_FETCH;
          end else begin
            nextState = S_WB;
          end
        end
      end

      S_WB: begin
        reg_wr_en  = 1'b1;
        pc_we      = 1'b1;
        retire     = 1'b1;
        reg_wr_sel = isLoad ? WR_SEL_MEM : (isJal ? WR_SEL_LINK : WR_SEL_ALU);
        pc_sel     = isJal ? PC_SEL_REG : PC_SEL_SEQ;
        nextState  = S_FETCH;
      end

      S_TRAP: begin
        trap = 1'b1;
      end

      default: begin
        nextState = S_IDLE;
      end
    endcase
  end

  // Register-file and ALU steering; indices a class does not use stay at 0.
  always_comb begin
    rd0_idx      = '0;
    rd1_idx      = '0;
    wr_idx       = '0;
    alu_func     = '0;
    alu_alt_op   = 1'b0;
    alu_src2_sel = 1'b0;
    imm          = '0;

    if (fieldsValid) begin
      alu_func     = ir[7:4];
      imm          = immField;
      alu_alt_op   = isCmp | isBranch;
      alu_src2_sel = isIType | isStore;
      if (writesReg) begin
        wr_idx = rdField;
      end
      if (isRType) begin
        rd0_idx = rs1Field;
        rd1_idx = rs2Field;
      end else if (isIType) begin
        rd0_idx = rs1Field;
      end else begin
        // STORE and BRANCH read the rd field as their first source operand.
        rd0_idx = rdField;
        rd1_idx = rs1Field;
      end
    end
  end

endmodule

// File: tb/tb_mc_proc_controller.sv
// Self-checking bench for mc_proc_controller: directed scenarios plus random
// instruction streams against a per-instruction timeline model.
module tb_mc_proc_controller;

  localparam int REG_IDX_W = 4;
  localparam int IMM_W     = 16;
  localparam int INSTRET_W = 4;
  localparam int INSTR_W   = 8 + IMM_W + 2 * REG_IDX_W;

  logic                 clk     = 1'b0;
  logic                 reset_n = 1'b1;
  logic                 alu_out = 1'b0;
  logic                 pc_we;
  logic [1:0]           pc_sel;
  logic                 reg_wr_en;
  logic [1:0]           reg_wr_sel;
  logic [REG_IDX_W-1:0] rd0_idx;
  logic [REG_IDX_W-1:0] rd1_idx;
  logic [REG_IDX_W-1:0] wr_idx;
  logic [3:0]           alu_func;
  logic                 alu_alt_op;
  logic                 alu_src2_sel;
  logic [IMM_W-1:0]     imm;
  logic                 retire;
  logic [INSTRET_W-1:0] instret;
  logic                 trap;

  int testsRun    = 0;
  int testsFailed = 0;
  int instretModel = 0;

  logic [3:0] legalOps [8] = '{4'h0, 4'h8, 4'h2, 4'hA, 4'h5, 4'h9, 4'h6, 4'hB};
  logic [3:0] illegalOps [8] = '{4'h1, 4'h3, 4'h4, 4'h7, 4'hC, 4'hD, 4'hE, 4'hF};

  always #5 clk = ~clk;

  mc_proc_controller_if #(.REG_IDX_W(REG_IDX_W), .IMM_W(IMM_W)) memBus ();

  mc_proc_controller #(
    .REG_IDX_W (REG_IDX_W),
    .IMM_W     (IMM_W),
    .INSTRET_W (INSTRET_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .memBus       (memBus),
    .alu_out      (alu_out),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .reg_wr_en    (reg_wr_en),
    .reg_wr_sel   (reg_wr_sel),
    .rd0_idx      (rd0_idx),
    .rd1_idx      (rd1_idx),
    .wr_idx       (wr_idx),
    .alu_func     (alu_func),
    .alu_alt_op   (alu_alt_op),
    .alu_src2_sel (alu_src2_sel),
    .imm          (imm),
    .retire       (retire),
    .instret      (instret),
    .trap         (trap)
  );

  logic [48:0] allOut;
  logic [5:0]  strobes;
  assign allOut = {pc_we, pc_sel, reg_wr_en, reg_wr_sel, rd0_idx, rd1_idx, wr_idx,
                   alu_func, alu_alt_op, alu_src2_sel, imm, retire, instret, trap,
                   memBus.imem_req, memBus.dmem_req, memBus.dmem_we};
  assign strobes = {memBus.imem_req, memBus.dmem_req, retire, pc_we, reg_wr_en, trap};

  // Reset asserted at an arbitrary moment; ends just after the first clock edge past release.
  task automatic apply_reset(input string tag);
    reset_n = 1'b0;
    #1;
    testsRun++;
    if (allOut !== '0) begin
      testsFailed++;
      $display("FAIL %s_outputs_in_reset: got %h expected 0", tag, allOut);
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    testsRun++;
    if ({memBus.imem_req, instret, trap} !== '0) begin
      testsFailed++;
      $display("FAIL %s_idle_after_release: got imem_req=%b instret=%0d trap=%b expected 0/0/0",
               tag, memBus.imem_req, instret, trap);
    end
    @(posedge clk);
    #1;
    instretModel = 0;
  endtask

  // Runs one legal instruction from the fetch cycle through retirement, acting
  // as both memories. Acks arriving outside an outstanding request are random.
  task automatic run_instr(input logic [31:0] instr, input int imemWait, input int dmemWait,
                           input logic aluVal, input string tag);
    logic [3:0] op;
    logic       rType, iType, cmp, isSt, isLd, isBr, isJal, isMem, wr, last, inMem;
    logic [3:0] rdF, rs1F, rs2F, expRd0, expRd1, expWr;
    logic [1:0] expPcSel, expWrSel;
    logic [5:0] expStrobes;
    int         total, memStart, memEnd;
    op    = instr[3:0];
    rType = (op == 4'h0) || (op == 4'h2);
    iType = (op == 4'h8) || (op == 4'hA) || (op == 4'h9) || (op == 4'hB);
    cmp   = (op == 4'h2) || (op == 4'hA);
    isSt  = (op == 4'h5);
    isLd  = (op == 4'h9);
    isBr  = (op == 4'h6);
    isJal = (op == 4'hB);
    isMem = isSt || isLd;
    wr    = rType || iType;
    rdF   = instr[31:28];
    rs1F  = instr[27:24];
    rs2F  = instr[23:20];
    if (rType) begin
      expRd0 = rs1F; expRd1 = rs2F;
    end else if (iType) begin
      expRd0 = rs1F; expRd1 = 4'h0;
    end else begin
      expRd0 = rdF;  expRd1 = rs1F;
    end
    expWr    = wr ? rdF : 4'h0;
    expPcSel = isBr ? {1'b0, aluVal} : (isJal ? 2'b10 : 2'b00);
    expWrSel = isLd ? 2'b01 : (isJal ? 2'b10 : 2'b00);
    // fetch (with waits) + decode + exec, then memory phase and write-back as needed
    total    = imemWait + 3 + (isMem ? dmemWait + 1 : 0) + (wr ? 1 : 0);
    memStart = imemWait + 3;
    memEnd   = memStart + dmemWait;

    for (int c = 0; c < total; c++) begin
      alu_out = aluVal;
      inMem   = isMem && (c >= memStart) && (c <= memEnd);
      last    = (c == total - 1);
      if (c <= imemWait) begin
        memBus.imem_ack   = (c == imemWait);
        memBus.imem_rdata = (c == imemWait) ? instr : $urandom;
      end else begin
        memBus.imem_ack   = 1'($urandom);
        memBus.imem_rdata = $urandom;
      end
      memBus.dmem_ack = inMem ? (c == memEnd) : 1'($urandom);
      expStrobes = {(c <= imemWait), inMem, last, last, (last && wr), 1'b0};
      @(negedge clk);
      testsRun++;
      if (strobes !== expStrobes) begin
        testsFailed++;
        $display("FAIL %s_strobes_c%0d: got req/dreq/ret/pcwe/wren/trap=%b expected %b",
                 tag, c, strobes, expStrobes);
      end
      if (inMem) begin
        testsRun++;
        if (memBus.dmem_we !== isSt) begin
          testsFailed++;
          $display("FAIL %s_dmem_we_c%0d: got %b expected %b", tag, c, memBus.dmem_we, isSt);
        end
      end
      if (c == imemWait + 1) begin
        testsRun++;
        if (imm !== instr[23:8]) begin
          testsFailed++;
          $display("FAIL %s_decode_imm: got %h expected %h", tag, imm, instr[23:8]);
        end
      end
      if (last) begin
        testsRun++;
        if (pc_sel !== expPcSel) begin
          testsFailed++;
          $display("FAIL %s_pc_sel: got %b expected %b", tag, pc_sel, expPcSel);
        end
        if (wr) begin
          testsRun++;
          if (reg_wr_sel !== expWrSel) begin
            testsFailed++;
            $display("FAIL %s_reg_wr_sel: got %b expected %b", tag, reg_wr_sel, expWrSel);
          end
          testsRun++;
          if (alu_src2_sel !== iType) begin
            testsFailed++;
            $display("FAIL %s_src2_sel: got %b expected %b", tag, alu_src2_sel, iType);
          end
        end
        testsRun++;
        if ({rd0_idx, rd1_idx, wr_idx, alu_func, alu_alt_op, imm} !==
            {expRd0, expRd1, expWr, instr[7:4], (cmp || isBr), instr[23:8]}) begin
          testsFailed++;
          $display("FAIL %s_fields: got rd0=%h rd1=%h wr=%h func=%h alt=%b imm=%h expected rd0=%h rd1=%h wr=%h func=%h alt=%b imm=%h",
                   tag, rd0_idx, rd1_idx, wr_idx, alu_func, alu_alt_op, imm,
                   expRd0, expRd1, expWr, instr[7:4], (cmp || isBr), instr[23:8]);
        end
      end
      @(posedge clk);
      #1;
    end
    instretModel = (instretModel + 1) % (1 << INSTRET_W);
    testsRun++;
    if (instret !== INSTRET_W'(instretModel)) begin
      testsFailed++;
      $display("FAIL %s_instret: got %0d expected %0d", tag, instret, instretModel);
    end
  endtask

  function automatic logic [31:0] random_legal();
    logic [31:0] instr;
    instr      = $urandom;
    instr[3:0] = legalOps[$urandom_range(0, 7)];
    return instr;
  endfunction

  task automatic test_reset();
    memBus.imem_ack   = 1'b0;
    memBus.imem_rdata = '0;
    memBus.dmem_ack   = 1'b0;
    #3;
    apply_reset("reset");
  endtask

  task automatic test_alu();
    run_instr(32'h1230_0010, 0, 0, 1'b0, "alu_r");
    run_instr(32'h7A5C_3E28, 2, 0, 1'b1, "alu_i_wait");
    run_instr(32'h4B00_9092, 0, 0, 1'b0, "cmp_r");
  endtask

  task automatic test_load_wait();
    run_instr(32'h5600_0409, 0, 3, 1'b0, "load_wait");
  endtask

  task automatic test_branch();
    run_instr(32'h1200_0066, 0, 0, 1'b1, "branch_taken");
    run_instr(32'h1200_0066, 0, 0, 1'b0, "branch_not_taken");
  endtask

  task automatic test_store();
    run_instr(32'h3400_0015, 0, 0, 1'b0, "store");
    run_instr(32'h9C12_34F5, 1, 2, 1'b1, "store_wait");
    run_instr(32'hE1AB_CD0B, 0, 0, 1'b0, "jal");
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      run_instr(random_legal(), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom), "random");
    end
  endtask

  task automatic test_instret_wrap();
    for (int i = 0; i < 16; i++) begin
      if (instretModel == (1 << INSTRET_W) - 2) break;
      run_instr(random_legal(), 0, 0, 1'($urandom), "wrap_approach");
    end
    run_instr(32'h1230_0010, 0, 0, 1'b0, "wrap_15");
    run_instr(32'h5600_0409, 1, 1, 1'b0, "wrap_0");
    testsRun++;
    if (instret !== '0) begin
      testsFailed++;
      $display("FAIL instret_wrap: got %0d expected 0", instret);
    end
  endtask

  task automatic test_reset_mid_mem();
    // LOAD whose data ack never arrives; reset lands in the middle of the MEM wait.
    for (int c = 0; c < 5; c++) begin
      memBus.imem_ack   = (c == 0);
      memBus.imem_rdata = 32'h5600_0409;
      memBus.dmem_ack   = 1'b0;
      @(negedge clk);
      if (c == 4) begin
        testsRun++;
        if ({memBus.dmem_req, memBus.dmem_we, instret} !== {1'b1, 1'b0, INSTRET_W'(instretModel)}) begin
          testsFailed++;
          $display("FAIL mid_mem_before_reset: got dmem_req=%b dmem_we=%b instret=%0d expected 1/0/%0d",
                   memBus.dmem_req, memBus.dmem_we, instret, instretModel);
        end
        #2;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    apply_reset("mid_mem");
    run_instr(32'h3400_0015, 0, 0, 1'b0, "after_mid_mem");
  endtask

  task automatic test_trap();
    for (int k = 0; k < 3; k++) begin
      logic [31:0] instr;
      instr      = $urandom;
      instr[3:0] = (k == 0) ? 4'hF : illegalOps[$urandom_range(0, 7)];
      for (int c = 0; c < 8; c++) begin
        memBus.imem_ack   = (c == 0) ? 1'b1 : 1'($urandom);
        memBus.imem_rdata = (c == 0) ? instr : $urandom;
        memBus.dmem_ack   = 1'($urandom);
        @(negedge clk);
        testsRun++;
        if (strobes !== ((c == 0) ? 6'b100000 : (c == 1) ? 6'b000000 : 6'b000001)) begin
          testsFailed++;
          $display("FAIL trap_op%h_c%0d: got req/dreq/ret/pcwe/wren/trap=%b", instr[3:0], c, strobes);
        end
        @(posedge clk);
        #1;
      end
      apply_reset("trap_clear");
      run_instr(random_legal(), 0, 1, 1'b1, "after_trap");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_branch();
    test_store();
    test_random();
    test_instret_wrap();
    test_reset_mid_mem();
    test_trap();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
